// File: rtl/inst_cache_pkg.sv
// Shared constants, state encodings and line types for the instruction cache.
package inst_cache_pkg;

  localparam int LINE_WORDS      = 4;
  localparam int OFFSET_WIDTH    = 4;
  localparam int LINE_ADDR_WIDTH = 32 - OFFSET_WIDTH;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {C_IDLE, C_LOOKUP, C_MISS, C_RESP} cache_state_t;
  typedef enum logic [1:0] {R_IDLE, R_MISS_REQ, R_MISS_WAIT} refill_state_t;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  function automatic logic [31:0] refill_addr(input logic [LINE_ADDR_WIDTH-1:0] line,
                                              input logic [1:0] word);
    return {line, word, 2'b00};
  endfunction

endpackage

// File: rtl/inst_cache_refill.sv
// Line refill engine: fetches words 0..3 of one line with single-word reads, one outstanding.
// Latency: one request/response round trip per word; done pulses with the last data_ok.
// Backpressure: mem_req and mem_addr are held stable until mem_addr_ok.
module inst_cache_refill
  import inst_cache_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LINE_ADDR_WIDTH-1:0] line_addr,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [31:0]                mem_rdata,
  output logic                       fill_done,
  output line_t                      fill_line,
  output line_t                      line_buf
);

  refill_state_t              rstate;
  logic [1:0]                 cnt;
  logic [LINE_ADDR_WIDTH-1:0] line_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate  <= R_IDLE;
      mem_req <= 1'b0;
      cnt     <= '0;
      line_r  <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (start) begin
            rstate  <= R_MISS_REQ;
            mem_req <= 1'b1;
            cnt     <= '0;
            line_r  <= line_addr;
          end
        end
        R_MISS_REQ: begin
          if (mem_addr_ok) begin
            rstate  <= R_MISS_WAIT;
            mem_req <= 1'b0;
          end
        end
        R_MISS_WAIT: begin
          if (mem_data_ok) begin
            line_buf[cnt] <= mem_rdata;
            if (cnt == 2'd3) begin
              rstate <= R_IDLE;
            end else begin
              cnt     <= cnt + 2'd1;
              rstate  <= R_MISS_REQ;
              mem_req <= 1'b1;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_req ? refill_addr(line_r, cnt) : 32'h0;
  assign fill_done = (rstate == R_MISS_WAIT) && mem_data_ok && (cnt == 2'd3);

  // The arrays are written on the same edge as the last word lands, so merge it in here.
  always_comb begin
    fill_line                 = line_buf;
    fill_line[LINE_WORDS-1]   = mem_rdata;
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache between the CPU fetch port and the AXI bridge.
// Latency: hit data_ok one cycle after addr_ok, back-to-back; miss adds four refill round trips plus one.
// Backpressure: addr_ok only in IDLE or on a LOOKUP hit; at most one CPU request outstanding.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic [31:0] cpu_inst_rdata,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok,
  input  logic [31:0] cache_inst_rdata
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINES     = 2 ** INDEX_WIDTH;

  cache_state_t           state;
  logic [31:2]            addr_r;
  logic [LINES-1:0]       valid;
  logic [TAG_WIDTH-1:0]   tag_ram  [LINES];
  line_t                  data_ram [LINES];

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   tag;
  logic [1:0]             word;
  logic                   hit;
  logic                   lookup_hit;
  logic                   fill_done;
  line_t                  fill_line;
  line_t                  line_buf;

  assign idx        = addr_r[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag        = addr_r[31 -: TAG_WIDTH];
  assign word       = addr_r[3:2];
  assign hit        = valid[idx] && (tag_ram[idx] == tag);
  assign lookup_hit = (state == C_LOOKUP) && hit;

  assign cpu_inst_addr_ok = cpu_inst_req && ((state == C_IDLE) || lookup_hit);
  assign cpu_inst_data_ok = lookup_hit || (state == C_RESP);
  assign cpu_inst_rdata   = lookup_hit          ? data_ram[idx][word] :
                            (state == C_RESP)   ? line_buf[word]      : 32'h0;

  assign cache_inst_wr    = 1'b0;
  assign cache_inst_size  = SIZE_WORD;
  assign cache_inst_wdata = 32'h0;

  // Write, size and wdata are meaningless on a read-only fetch port.
  logic unused_inputs;
  assign unused_inputs = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata, cpu_inst_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= C_IDLE;
      valid  <= '0;
      addr_r <= '0;
    end else begin
      case (state)
        C_IDLE: begin
          if (cpu_inst_req) begin
            addr_r <= cpu_inst_addr[31:2];
            state  <= C_LOOKUP;
          end
        end
        C_LOOKUP: begin
          if (hit) begin
            if (cpu_inst_req) addr_r <= cpu_inst_addr[31:2];
            else              state  <= C_IDLE;
          end else begin
            state <= C_MISS;
          end
        end
        C_MISS: begin
          if (fill_done) begin
            valid[idx] <= 1'b1;
            state      <= C_RESP;
          end
        end
        C_RESP:  state <= C_IDLE;
        default: state <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == C_MISS) && fill_done) begin
      tag_ram[idx]  <= tag;
      data_ram[idx] <= fill_line;
    end
  end

  inst_cache_refill u_refill (
    .clk         (clk),
    .rst         (rst),
    .start       ((state == C_LOOKUP) && !hit),
    .line_addr   (addr_r[31:OFFSET_WIDTH]),
    .mem_req     (cache_inst_req),
    .mem_addr    (cache_inst_addr),
    .mem_addr_ok (cache_inst_addr_ok),
    .mem_data_ok (cache_inst_data_ok),
    .mem_rdata   (cache_inst_rdata),
    .fill_done   (fill_done),
    .fill_line   (fill_line),
    .line_buf    (line_buf)
  );

endmodule
